jk_ff_bank: RTL



---
 rtl/jk_ff_bank.sv | 91 +++++++++
 1 files changed

// File: rtl/jk_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : jk_ff_bank
// Purpose  : WIDTH-bit JK flip-flop bank with JK / LOAD / TOGGLE / COUNT modes.
//            Define JKBANK_UPDOWN_EN to add the UP_DN port (up/down counting).
// Revision : 1.0  initial release
// ============================================================================
module jk_ff_bank #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             EN,
    input  logic             CLR,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
`ifdef JKBANK_UPDOWN_EN
    input  logic             UP_DN,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic             TC,
    output logic             CHG
);

    localparam logic [1:0] c_MODE_JK  = 2'b00;
    localparam logic [1:0] c_MODE_LD  = 2'b01;
    localparam logic [1:0] c_MODE_TGL = 2'b10;
    localparam logic [1:0] c_MODE_CNT = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             chg_q;
    logic             chg_d;
    logic             w_up;
    logic             w_term;
    logic [WIDTH-1:0] w_cnt_t;

`ifdef JKBANK_UPDOWN_EN
    assign w_up = UP_DN;
`else
    assign w_up = 1'b1;
`endif

    // Ripple-free toggle chain: bit i toggles when every lower bit is 1 (up) or 0 (down).
    assign w_cnt_t[0] = 1'b1;
    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_chain
            assign w_cnt_t[i] = w_cnt_t[i-1] & (w_up ? q_q[i-1] : ~q_q[i-1]);
        end
    endgenerate

    assign w_term = w_up ? (&q_q) : ~(|q_q);

    always_comb begin
        q_d = q_q;
        if (CLR) begin
            q_d = '0;
        end else if (EN) begin
            case (MODE)
                c_MODE_JK:  q_d = (J & ~q_q) | (~K & q_q);
                c_MODE_LD:  q_d = D;
                c_MODE_TGL: q_d = q_q ^ J;
                c_MODE_CNT: q_d = q_q ^ w_cnt_t;
                default:    q_d = q_q;
            endcase
        end
        chg_d = (q_d != q_q);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            q_q   <= RST_VAL;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign Q   = q_q;
    assign Q_n = ~q_q;
    assign CHG = chg_q;
    // Gated by RST_n so TC stays low while reset is held, even if RST_VAL is terminal.
    assign TC  = RST_n & ~CLR & EN & (MODE == c_MODE_CNT) & w_term;

endmodule
`default_nettype wire
